// File: rtl/framebuffer_scanout_pkg.sv
// Shared types and helpers for the framebuffer scanout path.
package typhoon_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int FRAME_PIXELS = H_RES * V_RES;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE,
    DRAIN
  } scanout_state_t;

  // Widen each channel by replicating its top bits into the new LSBs.
  function automatic logic [23:0] rgb565_to_rgb888(input rgb565_t p);
    return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
  endfunction

endpackage

// File: rtl/framebuffer_scanout_fifo.sv
// Synchronous pixel FIFO with flush, occupancy level and empty/full flags.
module scanout_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      level <= level + LW'(doPush) - LW'(doPop);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster-order SRAM prefetch into a pixel FIFO, expanded to 8-bit VGA colour.
module framebuffer_scanout #(
  parameter int          FIFO_DEPTH      = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          H_RES           = typhoon_pkg::H_RES,
  parameter int          V_RES           = typhoon_pkg::V_RES,
  parameter logic [19:0] FRAME1_BASE     = 20'h4B000,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF81F
) (
  input  logic                          BOARD_CLK,
  input  logic                          Reset,
  input  logic                          frameStart,
  input  logic                          doubleBuffer,
  input  logic                          pixelStrobe,
  input  logic                          blankN,
  output logic                          readReq,
  output logic [19:0]                   readAddress,
  input  logic                          readGrant,
  input  logic                          dataReady,
  input  logic [15:0]                   DataFromSRAM,
  output logic [7:0]                    VGA_R,
  output logic [7:0]                    VGA_G,
  output logic [7:0]                    VGA_B,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

  import typhoon_pkg::*;

  localparam int          OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [19:0] LAST_INDEX = 20'(H_RES * V_RES - 1);

  scanout_state_t state;
  scanout_state_t stateNext;

  logic [19:0]   pixIndex;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstandingNext;
  logic [OW-1:0] discardCount;
  logic [31:0]   inFlight;
  logic          transfer;
  logic          push;
  logic          pop;
  logic          fifoEmpty;
  logic          fifoFull;
  logic [15:0]   fifoData;

  assign transfer = readReq && readGrant;
  assign inFlight = 32'(fifoLevel) + 32'(outstanding);
  assign push     = dataReady && (discardCount == '0);
  assign pop      = pixelStrobe && blankN && !fifoEmpty;

  always_comb begin
    outstandingNext = outstanding;
    if (transfer && !dataReady)      outstandingNext = outstanding + 1'b1;
    else if (!transfer && dataReady) outstandingNext = outstanding - 1'b1;
  end

  always_ff @(posedge BOARD_CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (frameStart) begin
      stateNext = (outstandingNext != '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH:   if (transfer && pixIndex == LAST_INDEX) stateNext = DONE;
        DRAIN:   if (outstanding == '0) stateNext = FETCH;
        default: stateNext = state;
      endcase
    end
  end

  always_comb begin
    readReq = (state == FETCH)
           && (inFlight < 32'(FIFO_DEPTH))
           && (32'(outstanding) < 32'(MAX_OUTSTANDING));
  end

  // The frame base is loaded straight into the address counter, so no separate base register is kept.
  always_ff @(posedge BOARD_CLK or posedge Reset) begin
    if (Reset) begin
      readAddress  <= '0;
      pixIndex     <= '0;
      outstanding  <= '0;
      discardCount <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (frameStart) begin
        readAddress  <= doubleBuffer ? FRAME1_BASE : '0;
        pixIndex     <= '0;
        discardCount <= outstandingNext;
      end else begin
        if (transfer) begin
          readAddress <= readAddress + 1'b1;
          pixIndex    <= pixIndex + 1'b1;
        end
        if (dataReady && discardCount != '0) discardCount <= discardCount - 1'b1;
      end
    end
  end

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) pixelFifo (
    .clk    (BOARD_CLK),
    .rst    (Reset),
    .flush  (frameStart),
    .push   (push),
    .pop    (pop),
    .wrData (DataFromSRAM),
    .rdData (fifoData),
    .level  (fifoLevel),
    .empty  (fifoEmpty),
    .full   (fifoFull)
  );

  always_ff @(posedge BOARD_CLK or posedge Reset) begin
    if (Reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      underflow             <= 1'b0;
    end else begin
      if (pixelStrobe) begin
        if (!blankN)        {VGA_R, VGA_G, VGA_B} <= '0;
        else if (fifoEmpty) {VGA_R, VGA_G, VGA_B} <= rgb565_to_rgb888(rgb565_t'(UNDERFLOW_COLOR));
        else                {VGA_R, VGA_G, VGA_B} <= rgb565_to_rgb888(rgb565_t'(fifoData));
      end
      if (frameStart)                                underflow <= 1'b0;
      else if (pixelStrobe && blankN && fifoEmpty)   underflow <= 1'b1;
    end
  end

  // Credit accounting guarantees a return never finds the FIFO full.
  assert property (@(posedge BOARD_CLK) disable iff (Reset) !(push && fifoFull));

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout: small 8x4 frame, SRAM responder with 2-cycle latency.
module tb_framebuffer_scanout;

  localparam int          NPIX = 32;
  localparam logic [19:0] F1   = 20'h4B000;

  logic        BOARD_CLK = 1'b0;
  logic        Reset, frameStart, doubleBuffer, pixelStrobe, blankN;
  logic        readReq, readGrant, dataReady, underflow;
  logic [19:0] readAddress;
  logic [15:0] DataFromSRAM;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic [4:0]  fifoLevel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        blank;
    logic [15:0] pix;
    logic [7:0]  r, g, b;
  } vec_t;
  vec_t vecs[9];

  typedef struct {
    logic [19:0] addr;
    int          due;
  } ret_t;

  logic [15:0] mem0 [NPIX];
  ret_t        retQ[$];
  logic [19:0] grantLog[$];
  int          cyc      = 0;
  logic        respHold = 1'b0;

  framebuffer_scanout #(
    .FIFO_DEPTH      (16),
    .MAX_OUTSTANDING (4),
    .H_RES           (8),
    .V_RES           (4),
    .FRAME1_BASE     (F1),
    .UNDERFLOW_COLOR (16'hF81F)
  ) dut (
    .BOARD_CLK    (BOARD_CLK),
    .Reset        (Reset),
    .frameStart   (frameStart),
    .doubleBuffer (doubleBuffer),
    .pixelStrobe  (pixelStrobe),
    .blankN       (blankN),
    .readReq      (readReq),
    .readAddress  (readAddress),
    .readGrant    (readGrant),
    .dataReady    (dataReady),
    .DataFromSRAM (DataFromSRAM),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .underflow    (underflow),
    .fifoLevel    (fifoLevel)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  function automatic logic [15:0] sramRead(input logic [19:0] a);
    if (a < 20'(NPIX)) return mem0[a[4:0]];
    if (a == F1)       return 16'hF800;
    return a[15:0] ^ 16'h5555;
  endfunction

  function automatic logic [23:0] exp888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // SRAM responder: returns data two cycles after each grant, in order.
  initial begin
    dataReady    = 1'b0;
    DataFromSRAM = '0;
    forever begin
      @(negedge BOARD_CLK);
      cyc++;
      if (Reset) begin
        retQ.delete();
        dataReady = 1'b0;
      end else begin
        if (!respHold && retQ.size() > 0 && retQ[0].due <= cyc) begin
          dataReady    = 1'b1;
          DataFromSRAM = sramRead(retQ[0].addr);
          void'(retQ.pop_front());
        end else begin
          dataReady    = 1'b0;
          DataFromSRAM = '0;
        end
        if (readReq && readGrant) begin
          retQ.push_back('{addr: readAddress, due: cyc + 2});
          grantLog.push_back(readAddress);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge BOARD_CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pulseFs(input logic db);
    frameStart   = 1'b1;
    doubleBuffer = db;
    step();
    frameStart   = 1'b0;
  endtask

  task automatic strobe(input logic bl);
    pixelStrobe = 1'b1;
    blankN      = bl;
    step();
    pixelStrobe = 1'b0;
    blankN      = 1'b1;
  endtask

  task automatic waitLevel(input int tgt, input int maxCyc);
    for (int i = 0; i < maxCyc && int'(fifoLevel) != tgt; i++) step();
    chk("levelWait", 32'(fifoLevel), 32'(tgt));
  endtask

  initial begin
    int k;
    int popIdx;
    int start;
    logic sawReq;
    logic [4:0] maxLevel;

    vecs[0] = '{1'b1, 16'hF800, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 16'h07E0, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{1'b0, 16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 16'h001F, 8'h00, 8'h00, 8'hFF};
    vecs[4] = '{1'b1, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{1'b0, 16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 16'h8410, 8'h84, 8'h82, 8'h84};
    vecs[7] = '{1'b1, 16'h5AEB, 8'h5A, 8'h5D, 8'h5A};
    vecs[8] = '{1'b1, 16'h1234, 8'h10, 8'h45, 8'hA5};
    k = 0;
    for (int i = 0; i < 9; i++)
      if (vecs[i].blank) begin
        mem0[k] = vecs[i].pix;
        k++;
      end
    for (int i = k; i < NPIX; i++) mem0[i] = 16'(i * 16'h0841);

    Reset = 1'b1; frameStart = 1'b0; doubleBuffer = 1'b0;
    pixelStrobe = 1'b0; blankN = 1'b1; readGrant = 1'b0;
    step(); step();
    chk("rst readReq", 32'(readReq), 0);
    chk("rst readAddress", 32'(readAddress), 0);
    chk("rst VGA", {8'h00, VGA_R, VGA_G, VGA_B}, 0);
    chk("rst underflow", 32'(underflow), 0);
    chk("rst fifoLevel", 32'(fifoLevel), 0);
    Reset = 1'b0;
    step();
    chk("idle readReq", 32'(readReq), 0);

    // Prefetch from buffer 0 until the credit limit stalls requests.
    readGrant = 1'b1;
    pulseFs(1'b0);
    chk("fs0 readReq", 32'(readReq), 1);
    chk("fs0 readAddress", 32'(readAddress), 0);
    waitLevel(16, 100);
    chk("stall readReq", 32'(readReq), 0);
    chk("stall grants", 32'(grantLog.size()), 16);
    for (int i = 0; i < 4; i++)
      chk($sformatf("addr%0d", i), 32'(grantLog.size() > i ? grantLog[i] : 20'hFFFFF), 32'(i));

    for (int i = 0; i < 9; i++) begin
      strobe(vecs[i].blank);
      chk($sformatf("vec%0d R", i), 32'(VGA_R), 32'(vecs[i].r));
      chk($sformatf("vec%0d G", i), 32'(VGA_G), 32'(vecs[i].g));
      chk($sformatf("vec%0d B", i), 32'(VGA_B), 32'(vecs[i].b));
    end
    chk("vec underflow", 32'(underflow), 0);

    // Finish the frame and drain the FIFO, checking every remaining pixel.
    popIdx = 7;
    for (int i = 0; i < 600; i++) begin
      if (grantLog.size() >= NPIX && fifoLevel == 0) break;
      if (i % 3 == 0 && fifoLevel != 0 && popIdx < NPIX) begin
        strobe(1'b1);
        chk($sformatf("pix%0d", popIdx), {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, exp888(mem0[popIdx])});
        popIdx++;
      end else begin
        step();
      end
    end
    chk("frame grants", 32'(grantLog.size()), NPIX);
    chk("last addr", 32'(grantLog.size() > 0 ? grantLog[$] : 20'hFFFFF), NPIX - 1);
    chk("frame pops", 32'(popIdx), NPIX);
    sawReq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (readReq) sawReq = 1'b1;
    end
    chk("done no readReq", 32'(sawReq), 0);
    chk("done grants", 32'(grantLog.size()), NPIX);

    // Strobe an empty FIFO: underflow colour and sticky flag.
    strobe(1'b1);
    chk("uf colour", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h00FF00FF);
    chk("uf flag", 32'(underflow), 1);
    chk("uf level", 32'(fifoLevel), 0);
    for (int i = 0; i < 5; i++) step();
    chk("uf held", 32'(underflow), 1);

    // Buffer 1 frame start clears underflow and restarts at its base.
    pulseFs(1'b1);
    chk("fs1 underflow", 32'(underflow), 0);
    chk("fs1 readAddress", 32'(readAddress), 32'(F1));
    chk("fs1 readReq", 32'(readReq), 1);
    for (int i = 0; i < 20 && fifoLevel == 0; i++) step();
    strobe(1'b1);
    chk("fs1 pix", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
    chk("fs1 underflow kept", 32'(underflow), 0);

    // Frame start with three reads in flight: their returns are dropped.
    readGrant = 1'b0;
    for (int i = 0; i < 10; i++) step();
    respHold = 1'b1;
    pulseFs(1'b0);
    chk("flush level", 32'(fifoLevel), 0);
    start = grantLog.size();
    readGrant = 1'b1;
    for (int i = 0; i < 10 && grantLog.size() < start + 3; i++) step();
    readGrant = 1'b0;
    chk("three grants", 32'(grantLog.size() - start), 3);
    pulseFs(1'b0);
    chk("drain readReq", 32'(readReq), 0);
    respHold = 1'b0;
    maxLevel = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fifoLevel > maxLevel) maxLevel = fifoLevel;
    end
    chk("drain level", 32'(maxLevel), 0);
    chk("refetch readReq", 32'(readReq), 1);
    chk("refetch addr", 32'(readAddress), 0);
    start = grantLog.size();
    readGrant = 1'b1;
    step(); step();
    chk("refetch grant", 32'(grantLog.size() > start ? grantLog[start] : 20'hFFFFF), 0);

    // Asynchronous reset mid-fetch.
    for (int i = 0; i < 6; i++) step();
    strobe(1'b1);
    chk("pre-reset R", 32'(VGA_R), 32'h000000FF);
    #2 Reset = 1'b1;
    #1;
    chk("arst readReq", 32'(readReq), 0);
    chk("arst readAddress", 32'(readAddress), 0);
    chk("arst VGA", {8'h00, VGA_R, VGA_G, VGA_B}, 0);
    chk("arst underflow", 32'(underflow), 0);
    chk("arst fifoLevel", 32'(fifoLevel), 0);
    readGrant = 1'b0;
    step();
    Reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
Read-side counterpart to the tile-streaming framebuffer writer. It prefetches RGB565 pixels from the SRAM framebuffer in raster order through a read-request/grant port on the framebuffer controller, buffers them in a small FIFO, and emits 8-bit-per-channel VGA colour one cycle after each pixel strobe. It sits between the framebuffer controller and the VGA pins, alongside the VGA timing controller.

Parameters:
FIFO_DEPTH, 16, pixel FIFO entries (power of two, at least 4)
MAX_OUTSTANDING, 4, maximum granted reads awaiting data
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
FRAME1_BASE, 20'h4B000, SRAM word base of buffer 1 (buffer 0 base is 0)
UNDERFLOW_COLOR, 16'hF81F, RGB565 value shown on underflow

Ports:
BOARD_CLK  in  1  sole clock
Reset  in  1  asynchronous, active-high reset
frameStart  in  1  one-cycle pulse before the first active pixel of a frame
doubleBuffer  in  1  buffer select; sampled only on frameStart
pixelStrobe  in  1  one-cycle pulse per displayed pixel
blankN  in  1  0 = blanking interval
readReq  out  1  read request
readAddress  out  20  SRAM word address, stable while readReq=1
readGrant  in  1  request accepted this cycle
dataReady  in  1  read data valid; returns are in request order
DataFromSRAM  in  16  read data (RGB565)
VGA_R, VGA_G, VGA_B  out  8 each  registered colour
underflow  out  1  sticky; set on pop from an empty FIFO
fifoLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: state=IDLE; FIFO empty; outstanding=0; readReq=0; readAddress=0; VGA_R/G/B=0; underflow=0; fifoLevel=0.
- Reset is asynchronous, so an assertion mid-frame aborts all activity immediately. The controller must drop any in-flight grant on Reset.
- States:
  - IDLE: no requests. frameStart -> FETCH.
  - FETCH: requests pixels. When the request for pixel index H_RES*V_RES-1 is granted -> DONE.
  - DONE: no requests; data returns still land in the FIFO.
  - DRAIN: discards returns until outstanding=0, then -> FETCH.
- frameStart in any state:
  - Latch base = doubleBuffer ? FRAME1_BASE : 0.
  - Reset the pixel index to 0 and flush the FIFO.
  - Clear underflow.
  - Load discardCount=outstanding. Go to DRAIN if outstanding>0, otherwise FETCH.
  - A grant in the same cycle as frameStart is counted into discardCount.
- Request rule: readReq=1 in FETCH when fifoLevel+outstanding < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
- Once raised, readReq holds with readAddress stable until readGrant. A transfer occurs on readReq&&readGrant.
- readAddress = base + index. Keep it as a running counter incremented on each transfer; do not use a multiplier. 20-bit arithmetic, no wrap within a frame.
- outstanding: +1 on transfer, -1 on dataReady, unchanged when both occur in the same cycle.
- dataReady:
  - If discardCount>0, decrement discardCount and drop the data.
  - Otherwise push DataFromSRAM. A push while full cannot occur by the credit rule; assert this in simulation.
- Pop on pixelStrobe&&blankN. The colour registers update on the next edge (1-cycle latency).
- Colour expansion by bit replication:
  - R = {p[15:11], p[15:13]}
  - G = {p[10:5], p[10:9]}
  - B = {p[4:0], p[4:2]}
- blankN=0 on the strobe: output 0, no pop.
- Pixel strobe with an empty FIFO (including push in the same cycle; there is no bypass):
  - Output UNDERFLOW_COLOR, expanded; set underflow; no pop.
  - The image stays shifted until the next frameStart resynchronises it.
- Push and pop in the same cycle with a non-empty FIFO: both occur, fifoLevel unchanged.

Decomposition:
- Package typhoon_pkg:
  - H_RES, V_RES, FRAME_PIXELS
  - rgb565_t packed struct
  - scanout_state_t enum (IDLE, FETCH, DONE, DRAIN)
  - rgb565_to_rgb888 function
- Sub-module scanout_fifo: synchronous FIFO with push/pop/level/empty/full, one clock, async active-high reset.

Test Plan:
1. Reset, then frameStart with doubleBuffer=0, readGrant=1 always, dataReady 2 cycles after each grant -> first addresses 0,1,2,3; fifoLevel settles at 16; stall with readReq=0 at outstanding+level=16.
2. frameStart with doubleBuffer=1 -> first readAddress 20'h4B000. Feed pixel 16'hF800 and strobe -> VGA_R=8'hFF, VGA_G=0, VGA_B=0 one cycle later.
3. Full-frame run -> last granted address base+307199, state DONE, no further readReq.
4. Strobe with FIFO empty -> colour R=FF, G=00, B=FF; underflow=1; held until the next frameStart clears it.
5. frameStart with 3 reads outstanding -> the next 3 dataReady returns are dropped (fifoLevel stays 0), then a request at address 0 follows.
6. Assert Reset mid-fetch -> all outputs 0 immediately, without waiting for a clock edge.
